snes_input_arbiter: RTL and testbench

Parametrised arbiter that selects which of N controller input sources (board buttons, PS/2 keyboard, IR remote, …) drives the button vector sent to the SNES. It sits between the per-source decoders and the SNES serial output stage. It replaces a combinational "whichever differs" selector with a registered ownership FSM: first active source wins, is held until it goes idle for a programmable time, and is released immediately if disabled. A merge mode ORs all enabled sources instead.

---
 rtl/snes_input_pkg.sv | 13 +
 rtl/arb_idle_timer.sv | 32 +++
 rtl/snes_input_arbiter.sv | 152 +++++++++++++++
 tb/tb_snes_input_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/snes_input_pkg.sv
// snes_input_pkg: shared types for the SNES input arbiter.
// Arbitration state and mode encodings.
package snes_input_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    localparam logic MODE_OWN   = 1'b0;
    localparam logic MODE_MERGE = 1'b1;

endpackage

// File: rtl/arb_idle_timer.sv
// arb_idle_timer: counts consecutive idle owner samples.
// o_at_limit means the next idle sample ends ownership.
module arb_idle_timer #(
    parameter int IDLE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_at_limit
);

    localparam int CW = $clog2(IDLE_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(IDLE_CYCLES - 1);
    localparam logic [CW-1:0] SAT   = CW'(IDLE_CYCLES);

    logic [CW-1:0] r_cnt;

    // Clear has priority; increment stops at SAT so it never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != SAT)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_at_limit = (r_cnt >= LIMIT);

endmodule

// File: rtl/snes_input_arbiter.sv
// snes_input_arbiter: picks which input source drives the SNES.
// Ownership FSM with idle release, or OR-merge of all sources.
module snes_input_arbiter
    import snes_input_pkg::*;
#(
    parameter int N_SRC       = 3,
    parameter int BTN_W       = 4,
    parameter int IDLE_CYCLES = 1000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mode,
    input  logic [N_SRC*BTN_W-1:0]     src_btn,
    input  logic [N_SRC-1:0]           src_en,
    output logic [BTN_W-1:0]           button_press,
    output logic [$clog2(N_SRC)-1:0]   owner,
    output logic                       owner_valid
);

    localparam int OW = $clog2(N_SRC);

    arb_state_t       r_state;
    logic [OW-1:0]    r_owner;
    logic             r_valid;
    logic [BTN_W-1:0] r_btn;

    logic [BTN_W-1:0] w_src [N_SRC];
    logic             w_any;
    logic [OW-1:0]    w_sel;
    logic [BTN_W-1:0] w_sel_vec;
    logic [BTN_W-1:0] w_merge;
    logic [BTN_W-1:0] w_own_vec;
    logic             w_own_en;
    logic             w_own_zero;
    logic             w_at_limit;
    logic             w_inc;
    logic             w_release;

    // Disabled sources look exactly like idle sources.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            w_src[i] = src_btn[i*BTN_W +: BTN_W]
                     & {BTN_W{src_en[i]}};
        end
    end

    // Lowest active index wins; scan downward so it is written last.
    always_comb begin
        w_any     = 1'b0;
        w_sel     = '0;
        w_sel_vec = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (|w_src[i]) begin
                w_any     = 1'b1;
                w_sel     = OW'(i);
                w_sel_vec = w_src[i];
            end
        end
    end

    // OR of every enabled source for merge mode.
    always_comb begin
        w_merge = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_merge = w_merge | w_src[i];
        end
    end

    // Current owner's vector and enable.
    always_comb begin
        w_own_vec = '0;
        w_own_en  = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_owner == OW'(i)) begin
                w_own_vec = w_src[i];
                w_own_en  = src_en[i];
            end
        end
    end

    assign w_own_zero = ~|w_own_vec;

    // Count only while owned, enabled and idle; anything else clears.
    assign w_inc = (r_state == ARB_OWNED)
                && (mode == MODE_OWN)
                && w_own_en
                && w_own_zero
                && !w_at_limit;

    // Disable and timeout collapse into one release.
    assign w_release = !w_own_en
                    || (w_own_zero && w_at_limit);

    arb_idle_timer #(
        .IDLE_CYCLES(IDLE_CYCLES)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (!w_inc),
        .i_inc     (w_inc),
        .o_at_limit(w_at_limit)
    );

    // Ownership FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_owner <= '0;
            r_valid <= 1'b0;
            r_btn   <= '0;
        end else if (mode == MODE_MERGE) begin
            r_state <= ARB_IDLE;
            r_owner <= '0;
            r_valid <= 1'b0;
            r_btn   <= w_merge;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_state <= ARB_OWNED;
                        r_owner <= w_sel;
                        r_valid <= 1'b1;
                        r_btn   <= w_sel_vec;
                    end else begin
                        r_btn   <= '0;
                    end
                end
                ARB_OWNED: begin
                    if (w_release) begin
                        r_state <= ARB_IDLE;
                        r_owner <= '0;
                        r_valid <= 1'b0;
                        r_btn   <= '0;
                    end else begin
                        r_btn   <= w_own_vec;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_owner <= '0;
                    r_valid <= 1'b0;
                    r_btn   <= '0;
                end
            endcase
        end
    end

    assign button_press = r_btn;
    assign owner        = r_owner;
    assign owner_valid  = r_valid;

endmodule

// File: tb/tb_snes_input_arbiter.sv
// tb_snes_input_arbiter: directed plus random checks
// against a behavioural ownership model.
module tb_snes_input_arbiter;

    localparam int N = 3;
    localparam int W = 4;
    localparam int IDLE = 4;

    logic           clk;
    logic           reset;
    logic           mode;
    logic [N*W-1:0] src_btn;
    logic [N-1:0]   src_en;
    logic [W-1:0]   button_press;
    logic [1:0]     owner;
    logic           owner_valid;

    int n_vec;
    int n_bad;

    // model state: owning source (-1 = none) and idle run length
    int         m_own;
    int         m_run;
    logic [W-1:0] m_btn;

    snes_input_arbiter #(
        .N_SRC(N),
        .BTN_W(W),
        .IDLE_CYCLES(IDLE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .src_btn     (src_btn),
        .src_en      (src_en),
        .button_press(button_press),
        .owner       (owner),
        .owner_valid (owner_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] src_val(int i);
        logic [N*W-1:0] b;
        b = src_btn;
        return src_en[i] ? b[i*W +: W] : '0;
    endfunction

    task automatic model_reset();
        m_own = -1;
        m_run = 0;
        m_btn = '0;
    endtask

    // One clock edge of the arbitration rules.
    task automatic model_step();
        logic [W-1:0] v;
        if (mode) begin
            m_own = -1;
            m_run = 0;
            m_btn = '0;
            for (int i = 0; i < N; i++) m_btn |= src_val(i);
        end else if (m_own < 0) begin
            m_btn = '0;
            for (int i = 0; i < N; i++) begin
                if (m_own < 0 && src_val(i) != 0) begin
                    m_own = i;
                    m_run = 0;
                    m_btn = src_val(i);
                end
            end
        end else if (!src_en[m_own]) begin
            m_own = -1;
            m_run = 0;
            m_btn = '0;
        end else begin
            v = src_val(m_own);
            m_btn = v;
            if (v != 0) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run >= IDLE) begin
                    m_own = -1;
                    m_run = 0;
                end
            end
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_btn"}, 32'(button_press), 32'(m_btn));
        check({tag, "_vld"}, 32'(owner_valid),
              32'(m_own >= 0));
        check({tag, "_own"}, 32'(owner),
              32'(m_own < 0 ? 0 : m_own));
    endtask

    task automatic cycle(input logic m,
                         input logic [N*W-1:0] b,
                         input logic [N-1:0] e);
        mode    = m;
        src_btn = b;
        src_en  = e;
        @(posedge clk);
        model_step();
        #1;
        check_outs("cyc");
    endtask

    // Asserted between edges; outputs must clear at once.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_outs("rst_async");
        @(posedge clk);
        #1;
        check_outs("rst_hold");
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [N*W-1:0] pk(logic [W-1:0] s2,
                                          logic [W-1:0] s1,
                                          logic [W-1:0] s0);
        return {s2, s1, s0};
    endfunction

    initial begin
        logic [N*W-1:0] rb;
        logic [N-1:0]   re;
        logic           rm;
        n_vec   = 0;
        n_bad   = 0;
        mode    = 1'b0;
        src_btn = '0;
        src_en  = '1;
        reset   = 1'b0;
        model_reset();
        #2;
        do_reset();

        // grant of single source
        cycle(0, pk(0, 4'b0010, 0), 3'b111);
        check("tp1_owner", 32'(owner), 1);
        check("tp1_btn", 32'(button_press), 32'h2);
        cycle(0, pk(0, 0, 0), 3'b111);
        cycle(0, pk(0, 0, 0), 3'b111);
        cycle(0, pk(0, 0, 0), 3'b111);
        cycle(0, pk(0, 0, 0), 3'b111);
        check("tp1_timeout", 32'(owner_valid), 0);

        // simultaneous requests
        cycle(0, pk(4'b1000, 0, 4'b0001), 3'b111);
        check("tp2_owner", 32'(owner), 0);
        check("tp2_btn", 32'(button_press), 32'h1);

        // idle 3 then active: held; then idle 4: released
        for (int i = 0; i < 3; i++)
            cycle(0, pk(4'b1000, 0, 0), 3'b111);
        check("tp3_held", 32'(owner_valid), 1);
        check("tp3_src2_ign", 32'(button_press), 0);
        cycle(0, pk(4'b1000, 0, 4'b0100), 3'b111);
        check("tp3_btn", 32'(button_press), 32'h4);
        for (int i = 0; i < 3; i++)
            cycle(0, pk(4'b1000, 0, 0), 3'b111);
        check("tp3_still", 32'(owner_valid), 1);
        cycle(0, pk(4'b1000, 0, 0), 3'b111);
        check("tp3_rel", 32'(owner_valid), 0);
        cycle(0, pk(4'b1000, 0, 0), 3'b111);
        check("tp3_regrant", 32'(owner), 2);

        // disable the owner
        do_reset();
        cycle(0, pk(0, 4'b0011, 0), 3'b111);
        cycle(0, pk(0, 4'b0011, 0), 3'b101);
        check("tp4_dis_vld", 32'(owner_valid), 0);
        check("tp4_dis_btn", 32'(button_press), 0);

        // merge mode
        cycle(1, pk(4'b1000, 4'b0010, 4'b0001), 3'b101);
        check("tp5_merge", 32'(button_press), 32'h9);
        check("tp5_vld", 32'(owner_valid), 0);

        // reset mid-ownership then re-grant by priority
        cycle(0, pk(0, 4'b0100, 0), 3'b111);
        check("tp6_owned", 32'(owner), 1);
        do_reset();
        cycle(0, pk(4'b0001, 4'b0100, 0), 3'b111);
        check("tp6_regrant", 32'(owner), 1);

        // random traffic
        rm = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 59) == 0) rm = ~rm;
            for (int i = 0; i < N; i++) begin
                rb[i*W +: W] = ($urandom_range(0, 3) == 0)
                             ? W'($urandom) : '0;
                re[i] = ($urandom_range(0, 15) != 0);
            end
            if ($urandom_range(0, 499) == 0) do_reset();
            cycle(rm, rb, re);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
